// File: rtl/monitor_pkg.sv
// Shared definitions for the result monitor: state encodings, default run symbols and a
// saturating-increment helper.
package monitor_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StCheck   = 2'd1;
  localparam state_t StReport  = 2'd2;
  localparam state_t StTimeout = 2'd3;

  localparam int unsigned DefBeginSym = 32'h932;
  localparam int unsigned DefEndSym   = 32'hD5D;

  // Counters up to 32 bits wide pass through zero-extended and truncate the result back.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
    return (val >= max_val) ? max_val : val + 32'd1;
  endfunction

endpackage

// File: rtl/result_rom.sv
// Expected-value table for the Fibonacci up/down program; the last entry is the end symbol.
// Purely combinational on exp_idx so the monitor can sample it in the accept cycle.
module result_rom
  import monitor_pkg::*;
#(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned DATA_W = 32
) (
  input  logic [IDX_W-1:0]  exp_idx,
  output logic [DATA_W-1:0] exp_data
);

  localparam int unsigned NumEntries = 33;

  localparam logic [31:0] Table [NumEntries] = '{
    32'd0,   32'd1,   32'd1,   32'd2,   32'd3,   32'd5,   32'd8,   32'd13,
    32'd21,  32'd34,  32'd55,  32'd89,  32'd144, 32'd233, 32'd377, 32'd610,
    32'd610, 32'd377, 32'd233, 32'd144, 32'd89,  32'd55,  32'd34,  32'd21,
    32'd13,  32'd8,   32'd5,   32'd3,   32'd2,   32'd1,   32'd1,   32'd0,
    DefEndSym
  };

  always_comb begin
    exp_data = '0;
    if (exp_idx < IDX_W'(NumEntries)) begin
      exp_data = DATA_W'(Table[exp_idx]);
    end
  end

endmodule

// File: rtl/result_monitor.sv
// Bus-watching result checker: starts on a begin-symbol store to the test port, compares each
// later distinct store against exp_data and reports errors, duration, first mismatch and timeout.
module result_monitor
  import monitor_pkg::*;
#(
  parameter int unsigned ADDR_W    = 30,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned TEST_PORT = 'h40,
  parameter int unsigned BEGIN_SYM = DefBeginSym,
  parameter int unsigned CHECK_NUM = 33,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned ERR_W     = 8,
  parameter int unsigned DUR_W     = 16,
  parameter int unsigned TIMEOUT   = 16'hFFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  logic              wen,
  output logic [IDX_W-1:0]  exp_idx,
  input  logic [DATA_W-1:0] exp_data,
  output logic [ERR_W-1:0]  error_num,
  output logic [DUR_W-1:0]  duration,
  output logic [IDX_W-1:0]  first_err_idx,
  output logic [DATA_W-1:0] first_err_data,
  output logic              finish,
  output logic              pass,
  output logic              timed_out
);

  localparam logic [ERR_W-1:0] ErrMax = '1;
  localparam logic [DUR_W-1:0] DurMax = '1;

  state_t              state_q, state_d;
  logic                wen_q;
  logic [IDX_W-1:0]    exp_idx_q, exp_idx_d;
  logic [ERR_W-1:0]    error_num_q, error_num_d;
  logic [DUR_W-1:0]    duration_q, duration_d;
  logic [IDX_W-1:0]    first_err_idx_q, first_err_idx_d;
  logic [DATA_W-1:0]   first_err_data_q, first_err_data_d;

  logic at_port;
  logic accept;

  assign at_port = (addr == ADDR_W'(TEST_PORT));
  // A store held across DUT stall cycles is counted once, on its rising write enable.
  assign accept  = wen && !wen_q && at_port;

  always_comb begin
    state_d          = state_q;
    exp_idx_d        = exp_idx_q;
    error_num_d      = error_num_q;
    duration_d       = duration_q;
    first_err_idx_d  = first_err_idx_q;
    first_err_data_d = first_err_data_q;

    if (clear) begin
      state_d          = StIdle;
      exp_idx_d        = '0;
      error_num_d      = ErrMax;
      duration_d       = '0;
      first_err_idx_d  = '1;
      first_err_data_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          exp_idx_d   = '0;
          duration_d  = '0;
          error_num_d = ErrMax;
          if (wen && at_port && (data == DATA_W'(BEGIN_SYM))) begin
            error_num_d      = '0;
            first_err_idx_d  = '1;
            first_err_data_d = '0;
            state_d          = StCheck;
          end
        end
        StCheck: begin
          duration_d = DUR_W'(sat_inc(32'(duration_q), 32'(DurMax)));
          if (exp_idx_q == IDX_W'(CHECK_NUM)) begin
            state_d = StReport;
          end else begin
            if (accept) begin
              exp_idx_d = exp_idx_q + IDX_W'(1);
              if (data != exp_data) begin
                // error_num saturates and never wraps, so zero means no mismatch yet.
                if (error_num_q == '0) begin
                  first_err_idx_d  = exp_idx_q;
                  first_err_data_d = data;
                end
                error_num_d = ERR_W'(sat_inc(32'(error_num_q), 32'(ErrMax)));
              end
            end
            if (duration_q == DUR_W'(TIMEOUT - 1)) begin
              state_d = StTimeout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q          <= StIdle;
      wen_q            <= 1'b0;
      exp_idx_q        <= '0;
      error_num_q      <= ErrMax;
      duration_q       <= '0;
      first_err_idx_q  <= '1;
      first_err_data_q <= '0;
    end else begin
      state_q          <= state_d;
      wen_q            <= wen;
      exp_idx_q        <= exp_idx_d;
      error_num_q      <= error_num_d;
      duration_q       <= duration_d;
      first_err_idx_q  <= first_err_idx_d;
      first_err_data_q <= first_err_data_d;
    end
  end

  assign exp_idx        = exp_idx_q;
  assign error_num      = error_num_q;
  assign duration       = duration_q;
  assign first_err_idx  = first_err_idx_q;
  assign first_err_data = first_err_data_q;
  assign finish         = (state_q == StReport) || (state_q == StTimeout);
  assign pass           = (state_q == StReport) && (error_num_q == '0);
  assign timed_out      = (state_q == StTimeout);

endmodule

// File: tb/tb_result_monitor.sv
// Bench for result_monitor: two instances (default timeout and timeout 100) on a shared bus,
// a run-level behavioural model checked every cycle, plus hand-computed literal checks.
module tb_result_monitor;
  localparam logic [29:0] Tp       = 30'h40;
  localparam logic [31:0] BeginSym = 32'h932;
  localparam logic [31:0] EndSym   = 32'hD5D;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic [29:0] addr;
  logic [31:0] data;
  logic        wen;

  logic [5:0]  exp_idx_o  [2];
  logic [31:0] exp_data_w [2];
  logic [7:0]  err_o      [2];
  logic [15:0] dur_o      [2];
  logic [5:0]  fidx_o     [2];
  logic [31:0] fdata_o    [2];
  logic        fin_o      [2];
  logic        pass_o     [2];
  logic        to_o       [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_monitor u_dut (
    .clk(clk), .rst(rst), .clear(clear), .addr(addr), .data(data), .wen(wen),
    .exp_idx(exp_idx_o[0]), .exp_data(exp_data_w[0]), .error_num(err_o[0]),
    .duration(dur_o[0]), .first_err_idx(fidx_o[0]), .first_err_data(fdata_o[0]),
    .finish(fin_o[0]), .pass(pass_o[0]), .timed_out(to_o[0])
  );
  result_rom #(.IDX_W(6), .DATA_W(32)) u_rom0 (.exp_idx(exp_idx_o[0]), .exp_data(exp_data_w[0]));

  result_monitor #(.TIMEOUT(100)) u_dut_to (
    .clk(clk), .rst(rst), .clear(clear), .addr(addr), .data(data), .wen(wen),
    .exp_idx(exp_idx_o[1]), .exp_data(exp_data_w[1]), .error_num(err_o[1]),
    .duration(dur_o[1]), .first_err_idx(fidx_o[1]), .first_err_data(fdata_o[1]),
    .finish(fin_o[1]), .pass(pass_o[1]), .timed_out(to_o[1])
  );
  result_rom #(.IDX_W(6), .DATA_W(32)) u_rom1 (.exp_idx(exp_idx_o[1]), .exp_data(exp_data_w[1]));

  // Expected program output: Fibonacci 0..15 up, then back down, then the end symbol.
  logic [31:0] tab [33];
  initial begin
    int f [16];
    f[0] = 0; f[1] = 1;
    for (int k = 2; k < 16; k++) f[k] = f[k-1] + f[k-2];
    for (int k = 0; k < 16; k++) begin
      tab[k]      = 32'(f[k]);
      tab[16 + k] = 32'(f[15 - k]);
    end
    tab[32] = EndSym;
  end

  // Run-level model: phase 0 idle, 1 running, 2 reported, 3 aborted.
  int          m_phase [2];
  int          m_idx   [2];
  int          m_err   [2];
  int          m_dur   [2];
  int          m_fidx  [2];
  logic [31:0] m_fdata [2];
  bit          m_seen  [2];
  bit          m_prev_wen;
  int          m_limit [2] = '{65535, 100};

  task automatic model_reset(input int j);
    m_phase[j] = 0; m_idx[j] = 0; m_err[j] = 255; m_dur[j] = 0;
    m_fidx[j] = 63; m_fdata[j] = 0; m_seen[j] = 0;
  endtask

  task automatic model_step(input int j);
    bit new_store;
    int old_dur;
    new_store = wen && !m_prev_wen && (addr == Tp);
    if (clear) begin
      model_reset(j);
    end else if (m_phase[j] == 0) begin
      if (wen && addr == Tp && data == BeginSym) begin
        m_phase[j] = 1; m_err[j] = 0; m_seen[j] = 0; m_fidx[j] = 63; m_fdata[j] = 0;
      end
    end else if (m_phase[j] == 1) begin
      old_dur = m_dur[j];
      m_dur[j] = (old_dur + 1 > 65535) ? 65535 : old_dur + 1;
      if (m_idx[j] == 33) begin
        m_phase[j] = 2;
      end else begin
        if (new_store) begin
          if (data != tab[m_idx[j]]) begin
            if (!m_seen[j]) begin
              m_seen[j] = 1; m_fidx[j] = m_idx[j]; m_fdata[j] = data;
            end
            m_err[j] = (m_err[j] + 1 > 255) ? 255 : m_err[j] + 1;
          end
          m_idx[j]++;
        end
        if (old_dur == m_limit[j] - 1) m_phase[j] = 3;
      end
    end
  endtask

  initial begin
    model_reset(0); model_reset(1); m_prev_wen = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        model_reset(0); model_reset(1); m_prev_wen = 0;
      end else begin
        model_step(0); model_step(1); m_prev_wen = wen;
      end
    end
  end

  task automatic chk(input string nm, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        for (int j = 0; j < 2; j++) begin
          chk($sformatf("u%0d.exp_idx", j), exp_idx_o[j], m_idx[j]);
          chk($sformatf("u%0d.error_num", j), err_o[j], m_err[j]);
          chk($sformatf("u%0d.duration", j), dur_o[j], m_dur[j]);
          chk($sformatf("u%0d.first_err_idx", j), fidx_o[j], m_fidx[j]);
          chk($sformatf("u%0d.first_err_data", j), fdata_o[j], m_fdata[j]);
          chk($sformatf("u%0d.finish", j), fin_o[j], m_phase[j] >= 2);
          chk($sformatf("u%0d.pass", j), pass_o[j], m_phase[j] == 2 && m_err[j] == 0);
          chk($sformatf("u%0d.timed_out", j), to_o[j], m_phase[j] == 3);
        end
      end
    end
  end

  task automatic store(input logic [29:0] a, input logic [31:0] d, input int hold);
    addr = a; data = d; wen = 1'b1;
    repeat (hold) @(negedge clk);
    wen = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_seq(input int hold, input bit corrupt);
    logic [31:0] d;
    store(Tp, BeginSym, 1);
    for (int i = 0; i < 33; i++) begin
      d = tab[i];
      if (corrupt && (i == 5 || i == 20)) d = 32'd99;
      store(Tp, d, hold);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".exp_idx"}, exp_idx_o[0], 0);
    chk({tag, ".error_num"}, err_o[0], 255);
    chk({tag, ".duration"}, dur_o[0], 0);
    chk({tag, ".first_err_idx"}, fidx_o[0], 63);
    chk({tag, ".first_err_data"}, fdata_o[0], 0);
    chk({tag, ".finish"}, fin_o[0], 0);
    chk({tag, ".pass"}, pass_o[0], 0);
    chk({tag, ".timed_out"}, to_o[0], 0);
  endtask

  initial begin
    rst = 1'b0; clear = 1'b0; wen = 1'b0; addr = '0; data = '0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    #2 rst = 1'b1;
    @(negedge clk);

    // Clean run, single-cycle stores: 67 cycles in CHECK.
    run_seq(1, 0);
    chk("fib.pass", pass_o[0], 1);
    chk("fib.error_num", err_o[0], 0);
    chk("fib.duration", dur_o[0], 67);
    chk("fib.exp_idx", exp_idx_o[0], 33);
    do_clear();

    // Stores held 3 cycles: counted once each; the timeout-100 instance aborts.
    run_seq(3, 0);
    chk("stall.pass", pass_o[0], 1);
    chk("stall.duration", dur_o[0], 131);
    chk("stall.exp_idx", exp_idx_o[0], 33);
    chk("stall.to_inst_timed_out", to_o[1], 1);
    do_clear();

    // Two corrupted values.
    run_seq(1, 1);
    chk("corrupt.error_num", err_o[0], 2);
    chk("corrupt.first_err_idx", fidx_o[0], 5);
    chk("corrupt.first_err_data", fdata_o[0], 99);
    chk("corrupt.pass", pass_o[0], 0);
    chk("corrupt.finish", fin_o[0], 1);
    do_clear();

    // Begin symbol only: timeout after 100 CHECK cycles.
    store(Tp, BeginSym, 1);
    repeat (110) @(negedge clk);
    chk("tmo.timed_out", to_o[1], 1);
    chk("tmo.finish", fin_o[1], 1);
    chk("tmo.pass", pass_o[1], 0);
    chk("tmo.duration", dur_o[1], 100);
    chk("tmo.main_still_running", fin_o[0], 0);
    do_clear();

    // Asynchronous reset part-way through a run.
    store(Tp, BeginSym, 1);
    for (int i = 0; i < 10; i++) store(Tp, tab[i], 1);
    chk("midrst.exp_idx_before", exp_idx_o[0], 10);
    #2 rst = 1'b0;
    #1 chk_reset_vals("midrst");
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    run_seq(1, 0);
    chk("after_rst.pass", pass_o[0], 1);

    // Stores to a neighbouring address are ignored; clear in REPORT returns to IDLE.
    do_clear();
    store(Tp, BeginSym, 1);
    for (int i = 0; i < 33; i++) begin
      store(Tp + 30'd1, 32'hDEAD, 1);
      store(Tp, tab[i], 1);
    end
    repeat (3) @(negedge clk);
    chk("otheraddr.pass", pass_o[0], 1);
    chk("otheraddr.error_num", err_o[0], 0);
    do_clear();
    chk("clear.error_num", err_o[0], 255);
    chk("clear.finish", fin_o[0], 0);
    chk("clear.exp_idx", exp_idx_o[0], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
